// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone command master and its neighbours on the fabric.
// Address bits [SLV_SEL_MSB:SLV_SEL_LSB] choose the slave in the interconnect decoder.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int WB_ADDR_W   = 32;
    localparam int WB_DATA_W   = 32;
    localparam int SLV_SEL_LSB = 8;
    localparam int SLV_SEL_MSB = 15;
    localparam int TMO_CNT_W   = 16;

    localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator: one command in, one bus cycle, one response out.
// Latency: response valid 2 cycles after command accept at minimum (ack in first stb cycle).
// Backpressure: one outstanding transaction; o_cmd_ready is low from accept until the response
// handshake. Optional bus timeout under macro WB_CMD_TIMEOUT_EN.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int                ADDR_W         = WB_ADDR_W,
    parameter int                DATA_W         = WB_DATA_W,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(WB_ERR_DATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_wbm_cyc,
    output logic              o_wbm_stb,
    output logic              o_wbm_we,
    output logic [ADDR_W-1:0] o_wbm_addr,
    output logic [DATA_W-1:0] o_wbm_data,
    input  logic [DATA_W-1:0] i_wbm_data,
    input  logic              i_wbm_ack
);

    wb_state_e         state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              wbm_cyc_q, wbm_cyc_d;
    logic              wbm_we_q, wbm_we_d;
    logic [ADDR_W-1:0] wbm_addr_q, wbm_addr_d;
    logic [DATA_W-1:0] wbm_data_q, wbm_data_d;

`ifdef WB_CMD_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic                 rsp_err_q, rsp_err_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo_params;
    assign unused_tmo_params = ^{ERR_DATA, 32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        wbm_cyc_d   = wbm_cyc_q;
        wbm_we_d    = wbm_we_q;
        wbm_addr_d  = wbm_addr_q;
        wbm_data_d  = wbm_data_q;
`ifdef WB_CMD_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    wbm_we_d    = i_cmd_we;
                    wbm_addr_d  = i_cmd_addr;
                    wbm_data_d  = i_cmd_data;
                    wbm_cyc_d   = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
`ifdef WB_CMD_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                // Ack takes priority over an expiry on the same edge.
                if (i_wbm_ack) begin
                    rsp_data_d  = wbm_we_q ? '0 : i_wbm_data;
                    wbm_cyc_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef WB_CMD_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d  = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    wbm_cyc_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wbm_cyc_q   <= 1'b0;
            wbm_we_q    <= 1'b0;
            wbm_addr_q  <= '0;
            wbm_data_q  <= '0;
`ifdef WB_CMD_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wbm_cyc_q   <= wbm_cyc_d;
            wbm_we_q    <= wbm_we_d;
            wbm_addr_q  <= wbm_addr_d;
            wbm_data_q  <= wbm_data_d;
`ifdef WB_CMD_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_wbm_cyc   = wbm_cyc_q;
    assign o_wbm_stb   = wbm_cyc_q;
    assign o_wbm_we    = wbm_we_q;
    assign o_wbm_addr  = wbm_addr_q;
    assign o_wbm_data  = wbm_data_q;
`ifdef WB_CMD_TIMEOUT_EN
    assign o_rsp_err   = rsp_err_q;
`else
    assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: read, write, backpressure, timeout/no-timeout, reset, stray ack.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_wbm_cyc;
    logic        o_wbm_stb;
    logic        o_wbm_we;
    logic [31:0] o_wbm_addr;
    logic [31:0] o_wbm_data;
    logic [31:0] i_wbm_data;
    logic        i_wbm_ack;

    int checks = 0;
    int passed = 0;
    int stb_cnt;

    wb_cmd_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_we   (i_cmd_we),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_data (i_cmd_data),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_wbm_cyc  (o_wbm_cyc),
        .o_wbm_stb  (o_wbm_stb),
        .o_wbm_we   (o_wbm_we),
        .o_wbm_addr (o_wbm_addr),
        .o_wbm_data (o_wbm_data),
        .i_wbm_data (i_wbm_data),
        .i_wbm_ack  (i_wbm_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one command for exactly one accept edge; leaves the bench just after that edge.
    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_data  = data;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Count stb-high cycles until a response appears; ack is raised in stb cycle ack_at (0 = never).
    task automatic run_bus(input int ack_at, input logic [31:0] rdata, input logic [31:0] addr,
                           input string tag);
        stb_cnt = 0;
        for (int i = 0; i < 40 && !o_rsp_valid; i++) begin
            if (o_wbm_stb) begin
                stb_cnt++;
                chk({tag, "_addr"}, 64'(o_wbm_addr), 64'(addr));
            end
            i_wbm_ack  = (stb_cnt == ack_at);
            i_wbm_data = rdata;
            tick();
        end
        i_wbm_ack = 1'b0;
    endtask

    task automatic handshake();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_data = '0;
        i_rsp_ready = 1'b0; i_wbm_data = '0; i_wbm_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_cyc_stb",   64'({o_wbm_cyc, o_wbm_stb}), 64'd0);
        chk("rst_we",        64'(o_wbm_we), 64'd0);
        chk("rst_addr",      64'(o_wbm_addr), 64'd0);
        chk("rst_wdata",     64'(o_wbm_data), 64'd0);
        chk("rst_rsp",       64'({o_rsp_err, o_rsp_data}), 64'd0);

        // Read, ack in the third stb cycle
        send_cmd(1'b0, 32'h0000_0104, 32'h0);
        chk("rd_cmd_ready", 64'(o_cmd_ready), 64'd0);
        chk("rd_we",        64'(o_wbm_we), 64'd0);
        run_bus(3, 32'hCAFE_0001, 32'h0000_0104, "rd");
        chk("rd_stb_cycles", 64'(stb_cnt), 64'd3);
        chk("rd_rsp_valid",  64'(o_rsp_valid), 64'd1);
        chk("rd_rsp_data",   64'(o_rsp_data), 64'hCAFE_0001);
        chk("rd_rsp_err",    64'(o_rsp_err), 64'd0);
        chk("rd_cyc_off",    64'({o_wbm_cyc, o_wbm_stb}), 64'd0);
        handshake();
        chk("rd_hs_valid", 64'(o_rsp_valid), 64'd0);
        chk("rd_hs_ready", 64'(o_cmd_ready), 64'd1);

        // Write, ack in the first stb cycle: response visible after the second edge
        send_cmd(1'b1, 32'h0000_0200, 32'h1234_5678);
        chk("wr_we",    64'(o_wbm_we), 64'd1);
        chk("wr_wdata", 64'(o_wbm_data), 64'h1234_5678);
        chk("wr_stb",   64'(o_wbm_stb), 64'd1);
        chk("wr_not_yet", 64'(o_rsp_valid), 64'd0);
        i_wbm_ack = 1'b1; i_wbm_data = 32'hFFFF_FFFF;
        tick();
        i_wbm_ack = 1'b0;
        chk("wr_rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("wr_rsp_data",  64'(o_rsp_data), 64'd0);
        chk("wr_cyc_off",   64'(o_wbm_cyc), 64'd0);

        // Backpressure with a second command waiting
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 32'h0000_0300; i_cmd_data = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid",     64'(o_rsp_valid), 64'd1);
            chk("bp_data",      64'(o_rsp_data), 64'd0);
            chk("bp_cmd_ready", 64'(o_cmd_ready), 64'd0);
            chk("bp_cyc",       64'(o_wbm_cyc), 64'd0);
        end
        handshake();
        chk("bp_hs_valid", 64'(o_rsp_valid), 64'd0);
        chk("bp_hs_ready", 64'(o_cmd_ready), 64'd1);
        chk("bp_hs_nocyc", 64'(o_wbm_cyc), 64'd0);
        tick();
        i_cmd_valid = 1'b0;
        chk("bp2_cyc",  64'(o_wbm_cyc), 64'd1);
        chk("bp2_addr", 64'(o_wbm_addr), 64'h0000_0300);
        run_bus(1, 32'h5555_AAAA, 32'h0000_0300, "bp2");
        chk("bp2_data", 64'(o_rsp_data), 64'h5555_AAAA);
        handshake();

`ifdef WB_CMD_TIMEOUT_EN
        send_cmd(1'b0, 32'h0000_0400, 32'h0);
        run_bus(0, 32'h0, 32'h0000_0400, "to");
        chk("to_stb_cycles", 64'(stb_cnt), 64'd8);
        chk("to_valid",      64'(o_rsp_valid), 64'd1);
        chk("to_err",        64'(o_rsp_err), 64'd1);
        chk("to_data",       64'(o_rsp_data), 64'hDEAD_BEEF);
        handshake();
        send_cmd(1'b0, 32'h0000_0404, 32'h0);
        run_bus(8, 32'h0BAD_F00D, 32'h0000_0404, "tack");
        chk("tack_stb_cycles", 64'(stb_cnt), 64'd8);
        chk("tack_err",        64'(o_rsp_err), 64'd0);
        chk("tack_data",       64'(o_rsp_data), 64'h0BAD_F00D);
        handshake();
`else
        send_cmd(1'b0, 32'h0000_0400, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("nto_stb",   64'(o_wbm_stb), 64'd1);
        chk("nto_valid", 64'(o_rsp_valid), 64'd0);
        run_bus(1, 32'h0BAD_F00D, 32'h0000_0400, "nto");
        chk("nto_err",  64'(o_rsp_err), 64'd0);
        chk("nto_data", 64'(o_rsp_data), 64'h0BAD_F00D);
        handshake();
`endif

        // Reset while stb is high, then a late ack
        send_cmd(1'b0, 32'h0000_0500, 32'h0);
        chk("mr_stb", 64'(o_wbm_stb), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_cyc_stb",   64'({o_wbm_cyc, o_wbm_stb}), 64'd0);
        chk("mr_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("mr_cmd_ready", 64'(o_cmd_ready), 64'd1);
        i_wbm_ack = 1'b1; i_wbm_data = 32'h7777_7777;
        tick();
        i_wbm_ack = 1'b0;
        tick();
        chk("mr_late_valid", 64'(o_rsp_valid), 64'd0);
        chk("mr_late_ready", 64'(o_cmd_ready), 64'd1);

        // Stray ack in IDLE
        i_wbm_ack = 1'b1; i_wbm_data = 32'h8888_8888;
        tick();
        i_wbm_ack = 1'b0;
        tick();
        chk("stray_valid", 64'(o_rsp_valid), 64'd0);
        chk("stray_ready", 64'(o_cmd_ready), 64'd1);
        chk("stray_cyc",   64'(o_wbm_cyc), 64'd0);
        send_cmd(1'b0, 32'h0000_0600, 32'h0);
        run_bus(1, 32'h0101_0202, 32'h0000_0600, "post");
        chk("post_data", 64'(o_rsp_data), 64'h0101_0202);
        handshake();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone initiator that turns a simple valid/ready command stream into single classic Wishbone read/write cycles toward the slave-decoding interconnect.
- Returns one response (read data, or error flag) per command on a valid/ready response stream.
- Sits between host-side control logic (e.g. a PTP control/management engine) and the Wishbone fabric; its o_wbm_* outputs drive the interconnect's master port directly.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT_CYCLES, 256, cycles with stb high and no ack before abort (only with WB_CMD_TIMEOUT_EN); legal range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF, o_rsp_data value returned on timeout.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  block can accept a command.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_W  target address; bits [15:8] select the slave in the interconnect.
- i_cmd_data  in  DATA_W  write data.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  DATA_W  read data; 0 for writes; ERR_DATA on timeout.
- o_rsp_err  out  1  1 = cycle aborted by timeout.
- o_wbm_cyc  out  1  Wishbone cycle.
- o_wbm_stb  out  1  Wishbone strobe.
- o_wbm_we  out  1  Wishbone write enable.
- o_wbm_addr  out  ADDR_W  Wishbone address.
- o_wbm_data  out  DATA_W  Wishbone write data.
- i_wbm_data  in  DATA_W  Wishbone read data.
- i_wbm_ack  in  1  Wishbone acknowledge.

Behaviour:
- Reset values (synchronous, at the edge where rst=1): state IDLE; o_cmd_ready=1; o_rsp_valid=0; o_rsp_err=0; o_rsp_data=0; o_wbm_cyc=0; o_wbm_stb=0; o_wbm_we=0; o_wbm_addr=0; o_wbm_data=0; timeout counter=0.
- Reset mid-cycle: cyc/stb fall at that edge; a pending response is discarded; no response is ever produced for the aborted command.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid at edge N: latch we/addr/data onto o_wbm_*, set cyc=stb=1 from cycle N+1, clear counter, go BUS.
- BUS:
  - o_cmd_ready=0; cyc/stb held high; addr/data/we stable.
  - i_wbm_ack sampled at edge M: capture i_wbm_data (reads) or 0 (writes) into o_rsp_data, err=0, cyc=stb=0 and o_rsp_valid=1 from M+1, go RESP.
  - Minimum command-to-response latency is 2 cycles (ack in the first stb cycle).
- RESP:
  - o_rsp_valid held with stable data/err until i_rsp_ready.
  - On the handshake edge: o_rsp_valid=0, o_cmd_ready=1, go IDLE.
  - The next command is accepted no earlier than the following cycle, so there is exactly one outstanding transaction.
- i_wbm_ack outside BUS is ignored.
- Counter width is 16 bits, saturating; it does not wrap.

Optional Feature:
- Macro: WB_CMD_TIMEOUT_EN.
- Defined:
  - Counter increments each BUS cycle without ack.
  - When counter reaches TIMEOUT_CYCLES-1 with no ack: cyc/stb drop, o_rsp_data=ERR_DATA, o_rsp_err=1, go RESP.
  - Ack on the same edge as expiry wins: normal response, err=0.
- Undefined: no counter logic; BUS waits indefinitely; o_rsp_err is tied 0.

Decomposition:
- Shared package wb_pkg holds:
  - state enum (IDLE/BUS/RESP);
  - WB_ADDR_W/WB_DATA_W defaults;
  - slave-select field constants (SLV_SEL_LSB=8, SLV_SEL_MSB=15);
  - default ERR_DATA.
- No sub-module required. The timeout counter is inline, under the macro.

Test Plan:
- Read: cmd we=0, addr=32'h0000_0104; slave acks with 32'hCAFE_0001 two cycles after stb -> cyc/stb high exactly 3 cycles, addr 0x104 stable throughout, o_rsp_data=32'hCAFE_0001, err=0.
- Write: cmd we=1, addr=32'h0000_0200, data=32'h1234_5678; ack in the first stb cycle -> o_wbm_we=1, o_wbm_data=32'h1234_5678, response at cmd edge+2, o_rsp_data=0.
- Backpressure: hold i_rsp_ready=0 for 5 cycles after rsp_valid; present a second command meanwhile -> o_rsp_valid and data stable, o_cmd_ready=0, second command accepted only after the response handshake.
- Timeout (macro on, TIMEOUT_CYCLES=8): no ack -> stb high exactly 8 cycles, then o_rsp_err=1, o_rsp_data=32'hDEAD_BEEF. Repeat with ack on the 8th cycle -> err=0 with real data.
- Reset mid-BUS: assert rst for 1 cycle while stb is high -> cyc/stb/rsp_valid all 0 after that edge, o_cmd_ready=1, no stray response; a late ack is ignored.
- Stray ack in IDLE: pulse i_wbm_ack with no command -> no response, state stays IDLE.
